cellram_sync_responder: RTL and testbench

Synthesizable CellularRAM responder implementing the device side of the synchronous burst protocol: it latches address on ADV#, counts initial latency, drives WAIT, and sources or sinks burst data from a small internal memory. It also holds the BCR/RCR configuration registers, written and read through CRE cycles. It sits in the FPGA loopback build in place of the external PSRAM, so the CellularRAM controller can be exercised on hardware and in RTL simulation without the vendor model.

---
 rtl/cellram_sync_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_cellram_sync_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellram_sync_responder.sv
// cellram_sync_responder
//
// Device side of the CellularRAM synchronous burst protocol, used in place of
// the external PSRAM in the loopback build. An access starts on the edge where
// ce_n and adv_n are both low (E0). That edge latches the address, cre and
// we_n. The initial latency (BCR latency code) is counted, WAIT is driven, and
// burst data is then sourced from or sunk into a small internal memory. CRE
// accesses read or write the BCR/RCR configuration registers.
//
// Ports:
//   clk        device clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   adv_n      address valid, active low (starts an access while ce_n=0)
//   ce_n       chip enable, active low (high returns to idle)
//   oe_n       output enable, active low (gates dq_oe)
//   we_n       0 = write access, 1 = read access (sampled at E0)
//   cre        1 = configuration register access (sampled at E0)
//   ub_n/lb_n  byte enables for writes, active low
//   addr       address, or configuration value on a CRE write
//   dq_i       write data
//   dq_o       registered read data
//   dq_oe      read data output enable
//   o_wait     registered WAIT pin, polarity from BCR[10]
//   o_wait_oe  high while an access is active
module cellram_sync_responder #(
    parameter int          ADDR_BITS = 23,
    parameter int          MEM_BITS  = 10,
    parameter int          DQ_BITS   = 16,
    parameter int          REG_SEL   = 18,
    parameter logic [15:0] BCR_RESET = 16'h1D1F,
    parameter logic [15:0] RCR_RESET = 16'h0010
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adv_n,
    input  logic                 ce_n,
    input  logic                 oe_n,
    input  logic                 we_n,
    input  logic                 cre,
    input  logic                 ub_n,
    input  logic                 lb_n,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DQ_BITS-1:0]   dq_i,
    output logic [DQ_BITS-1:0]   dq_o,
    output logic                 dq_oe,
    output logic                 o_wait,
    output logic                 o_wait_oe
);

    localparam int LANE  = DQ_BITS / 2;
    localparam int DEPTH = 1 << MEM_BITS;

    typedef enum logic [1:0] {IDLE, LATENCY, DATA, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          lat_cnt_q, lat_cnt_d;
    logic [MEM_BITS-1:0] beat_q, beat_d;     // index of the word currently on the bus
    logic [MEM_BITS-1:0] base_q, base_d;     // a_0
    logic                is_rd_q, is_rd_d;
    logic                cre_q, cre_d;
    logic [1:0]          sel_q, sel_d;
    logic [4:0]          len_q, len_d;       // 0 = continuous
    logic                wrap_q, wrap_d;
    logic                pol_q, pol_d;       // asserted WAIT level for this access
    logic                early_q, early_d;
    logic                wait_q, wait_d;
    logic [15:0]         bcr_q, bcr_d;
    logic [15:0]         rcr_q, rcr_d;

    logic                xfer;               // this edge moves word beat_d
    logic [3:0]          lc_start;
    logic [MEM_BITS-1:0] xfer_addr;
    logic [MEM_BITS-1:0] wrap_mask;
    logic [MEM_BITS-1:0] seq_addr;
    logic                mem_wr;
    logic                mem_rd;
    logic                cfg_rd;
    logic [1:0]          byte_en;
    logic [DQ_BITS-1:0]  cfg_val;
    logic                unused_bits;

    function automatic logic [4:0] burst_len(input logic [2:0] code);
        case (code)
            3'b001:  return 5'd4;
            3'b010:  return 5'd8;
            3'b011:  return 5'd16;
            default: return 5'd0;
        endcase
    endfunction

    // Latency code 0 encodes 8 cycles.
    assign lc_start = (bcr_q[13:11] == 3'd0) ? 4'd8 : {1'b0, bcr_q[13:11]};

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        base_d    = base_q;
        is_rd_d   = is_rd_q;
        cre_d     = cre_q;
        sel_d     = sel_q;
        len_d     = len_q;
        wrap_d    = wrap_q;
        pol_d     = pol_q;
        early_d   = early_q;
        wait_d    = wait_q;
        bcr_d     = bcr_q;
        rcr_d     = rcr_q;
        xfer      = 1'b0;

        if (ce_n) begin
            state_d = IDLE;
            wait_d  = ~bcr_q[10];
        end else if (!adv_n) begin
            // New access; also aborts any burst in progress without a transfer.
            // Timing comes from the BCR value before any write at this edge.
            state_d   = LATENCY;
            lat_cnt_d = lc_start;
            beat_d    = '0;
            base_d    = addr[MEM_BITS-1:0];
            is_rd_d   = we_n;
            cre_d     = cre;
            sel_d     = addr[REG_SEL+1:REG_SEL];
            len_d     = cre ? 5'd1 : burst_len(bcr_q[2:0]);
            wrap_d    = ~bcr_q[3];
            pol_d     = bcr_q[10];
            early_d   = bcr_q[8];
            // Early-deassert with a one-cycle latency leaves WAIT inactive.
            wait_d    = (bcr_q[8] && lc_start == 4'd1) ? ~bcr_q[10] : bcr_q[10];
            if (cre && !we_n) begin
                if (addr[REG_SEL+1:REG_SEL] == 2'b10) begin
                    bcr_d = addr[15:0];
                end else if (addr[REG_SEL+1:REG_SEL] == 2'b00) begin
                    rcr_d = addr[15:0];
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    wait_d = ~bcr_q[10];
                end
                LATENCY: begin
                    if (lat_cnt_q == 4'd1) begin
                        state_d = DATA;
                        wait_d  = ~pol_q;
                        xfer    = 1'b1;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 4'd1;
                        // One cycle before the first data edge.
                        if (early_q && lat_cnt_q == 4'd2) begin
                            wait_d = ~pol_q;
                        end
                    end
                end
                DATA: begin
                    if (len_q != 5'd0 && beat_q == MEM_BITS'(len_q - 5'd1)) begin
                        state_d = DONE;
                        wait_d  = pol_q;
                    end else begin
                        beat_d = beat_q + MEM_BITS'(1);
                        xfer   = 1'b1;
                    end
                end
                default: begin
                    // DONE holds until ce_n rises or a new adv_n pulse.
                end
            endcase
        end
    end

    // Word address: linear, or wrapping inside the length-aligned block.
    always_comb begin
        wrap_mask = MEM_BITS'(len_q - 5'd1);
        seq_addr  = base_q + beat_d;
        if (wrap_q && len_q != 5'd0) begin
            xfer_addr = (base_q & ~wrap_mask) | (seq_addr & wrap_mask);
        end else begin
            xfer_addr = seq_addr;
        end
    end

    assign mem_wr  = xfer & ~is_rd_q & ~cre_q & ~reset;
    assign mem_rd  = xfer & is_rd_q & ~cre_q;
    assign cfg_rd  = xfer & is_rd_q & cre_q;
    assign byte_en = {~ub_n, ~lb_n};
    assign cfg_val = (sel_q == 2'b10) ? DQ_BITS'(bcr_q) :
                     (sel_q == 2'b00) ? DQ_BITS'(rcr_q) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            base_q    <= '0;
            is_rd_q   <= 1'b0;
            cre_q     <= 1'b0;
            sel_q     <= '0;
            len_q     <= '0;
            wrap_q    <= 1'b0;
            pol_q     <= BCR_RESET[10];
            early_q   <= 1'b0;
            wait_q    <= ~BCR_RESET[10];
            bcr_q     <= BCR_RESET;
            rcr_q     <= RCR_RESET;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            is_rd_q   <= is_rd_d;
            cre_q     <= cre_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            wrap_q    <= wrap_d;
            pol_q     <= pol_d;
            early_q   <= early_d;
            wait_q    <= wait_d;
            bcr_q     <= bcr_d;
            rcr_q     <= rcr_d;
        end
    end

    // One RAM per byte lane; the lane output register doubles as dq_o.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [LANE-1:0] mem [DEPTH];
            logic [LANE-1:0] lane_q;

            always_ff @(posedge clk) begin
                if (mem_wr && byte_en[gi]) begin
                    mem[xfer_addr] <= dq_i[gi*LANE +: LANE];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_q <= '0;
                end else if (mem_rd) begin
                    lane_q <= mem[xfer_addr];
                end else if (cfg_rd) begin
                    lane_q <= cfg_val[gi*LANE +: LANE];
                end
            end

            assign dq_o[gi*LANE +: LANE] = lane_q;
        end
    endgenerate

    assign dq_oe     = (state_q == DATA) & is_rd_q & ~oe_n;
    assign o_wait    = wait_q;
    assign o_wait_oe = (state_q != IDLE);

    // Only some address and BCR bits carry meaning here.
    assign unused_bits = ^{addr, bcr_q};

endmodule

// File: tb/tb_cellram_sync_responder.sv
module tb_cellram_sync_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        adv_n, ce_n, oe_n, we_n, cre, ub_n, lb_n;
    logic [22:0] addr;
    logic [15:0] dq_i;
    logic [15:0] dq_o;
    logic        dq_oe, o_wait, o_wait_oe;

    always #5 clk = ~clk;

    cellram_sync_responder dut (
        .clk       (clk),
        .reset     (reset),
        .adv_n     (adv_n),
        .ce_n      (ce_n),
        .oe_n      (oe_n),
        .we_n      (we_n),
        .cre       (cre),
        .ub_n      (ub_n),
        .lb_n      (lb_n),
        .addr      (addr),
        .dq_i      (dq_i),
        .dq_o      (dq_o),
        .dq_oe     (dq_oe),
        .o_wait    (o_wait),
        .o_wait_oe (o_wait_oe)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_bcr, m_rcr;
    logic [15:0] m_mem [1024];
    bit          m_valid [1024];

    // Per-access write data and captured read data
    logic [15:0] wdata [64];
    logic        wub [64];
    logic        wlb [64];
    logic [15:0] rdata [64];

    typedef struct {
        int          a;
        logic [15:0] prior;
        logic [15:0] newv;
        logic        ub;
        logic        lb;
        logic [15:0] expv;
    } mask_vec_t;

    mask_vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lc_of(input logic [15:0] b);
        return (b[13:11] == 3'd0) ? 8 : int'(b[13:11]);
    endfunction

    function automatic int len_of(input logic [15:0] b);
        case (b[2:0])
            3'b001:  return 4;
            3'b010:  return 8;
            3'b011:  return 16;
            default: return 0;
        endcase
    endfunction

    // Address of word k of a burst starting at a0 (L=0 means continuous).
    function automatic int addr_k(input int a0, input int k, input int len, input bit wrap);
        if (len == 0 || !wrap) return (a0 + k) % 1024;
        return (a0 - (a0 % len)) + ((a0 % len) + k) % len;
    endfunction

    // Start an access at the next edge (E0) and run 'cycles' more edges,
    // checking every cycle against the model. No ce_n release at the end.
    task automatic run_access(input int a, input bit is_wr, input bit is_cre,
                              input int cycles, input bit oe_low);
        int          lc, len, d, sel, k, k1, ak, a0;
        bit          pol, wrap, in_data, exp_wait, exp_oe;
        logic [15:0] cfgv;
        lc   = lc_of(m_bcr);
        len  = is_cre ? 1 : len_of(m_bcr);
        wrap = !m_bcr[3];
        pol  = m_bcr[10];
        d    = m_bcr[8] ? lc - 1 : lc;
        sel  = (a >> 18) & 3;
        a0   = a & 1023;
        $display("access addr=%06h wr=%0d cre=%0d cycles=%0d lc=%0d len=%0d wrap=%0d",
                 a, is_wr, is_cre, cycles, lc, len, wrap);
        ce_n  = 1'b0;
        adv_n = 1'b0;
        addr  = 23'(a);
        we_n  = !is_wr;
        cre   = is_cre;
        oe_n  = !oe_low;
        tick();
        adv_n = 1'b1;
        if (is_cre && is_wr) begin
            if (sel == 2) m_bcr = a[15:0];
            else if (sel == 0) m_rcr = a[15:0];
        end
        cfgv = (sel == 2) ? m_bcr : (sel == 0) ? m_rcr : 16'h0000;
        for (int t = 0; t < cycles; t++) begin
            in_data  = (t >= lc) && (len == 0 || t < lc + len);
            exp_wait = (t < d) ? pol : ((len != 0 && t >= lc + len) ? pol : !pol);
            exp_oe   = in_data && !is_wr && oe_low;
            chk("o_wait", 32'(o_wait), 32'(exp_wait));
            chk("o_wait_oe", 32'(o_wait_oe), 32'd1);
            chk("dq_oe", 32'(dq_oe), 32'(exp_oe));
            if (in_data && !is_wr) begin
                k = t - lc;
                rdata[k] = dq_o;
                if (is_cre) begin
                    chk("cfg_rd", 32'(dq_o), 32'(cfgv));
                end else begin
                    ak = addr_k(a0, k, len, wrap);
                    if (m_valid[ak]) chk("mem_rd", 32'(dq_o), 32'(m_mem[ak]));
                end
            end
            k1 = t + 1 - lc;
            if (is_wr && !is_cre && k1 >= 0 && (len == 0 || k1 < len)) begin
                dq_i = wdata[k1];
                ub_n = wub[k1];
                lb_n = wlb[k1];
                ak   = addr_k(a0, k1, len, wrap);
                if (!wub[k1]) m_mem[ak][15:8] = wdata[k1][15:8];
                if (!wlb[k1]) m_mem[ak][7:0]  = wdata[k1][7:0];
                if (!wub[k1] && !wlb[k1]) m_valid[ak] = 1'b1;
            end else begin
                dq_i = 16'($urandom);
                ub_n = 1'($urandom);
                lb_n = 1'($urandom);
            end
            tick();
        end
    endtask

    task automatic end_access();
        ce_n  = 1'b1;
        adv_n = 1'b1;
        tick();
        chk("end_dq_oe", 32'(dq_oe), 32'd0);
        chk("end_wait_oe", 32'(o_wait_oe), 32'd0);
        chk("end_wait", 32'(o_wait), 32'(!m_bcr[10]));
    endtask

    task automatic fill_words(input int n);
        for (int i = 0; i < n; i++) begin
            wdata[i] = 16'($urandom);
            wub[i]   = 1'b0;
            wlb[i]   = 1'b0;
        end
    endtask

    initial begin
        int lc, len, cyc, sel, a;
        logic [15:0] b;
        logic [2:0]  bl;

        tbl[0] = '{32'h020, 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h12CD};
        tbl[1] = '{32'h021, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'hAB34};
        tbl[2] = '{32'h022, 16'h1234, 16'hABCD, 1'b1, 1'b1, 16'h1234};
        tbl[3] = '{32'h023, 16'h5A5A, 16'hC3E1, 1'b0, 1'b0, 16'hC3E1};

        reset = 1'b1; adv_n = 1'b1; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        cre = 1'b0; ub_n = 1'b1; lb_n = 1'b1; addr = '0; dq_i = '0;
        m_bcr = 16'h1D1F;
        m_rcr = 16'h0010;
        tick();
        tick();
        chk("rst_dq_o", 32'(dq_o), 32'd0);
        chk("rst_dq_oe", 32'(dq_oe), 32'd0);
        chk("rst_wait", 32'(o_wait), 32'd0);
        chk("rst_wait_oe", 32'(o_wait_oe), 32'd0);
        reset = 1'b0;
        tick();

        // Config reads of the reset register values
        run_access(0, 1'b0, 1'b1, lc_of(m_bcr) + 2, 1'b1);
        chk("rcr_reset", 32'(rdata[0]), 32'h0010);
        end_access();
        run_access(2 << 18, 1'b0, 1'b1, lc_of(m_bcr) + 2, 1'b1);
        chk("bcr_reset", 32'(rdata[0]), 32'h1D1F);
        end_access();

        // Four-word continuous write/read at 0x010
        wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333; wdata[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin wub[i] = 1'b0; wlb[i] = 1'b0; end
        run_access(32'h010, 1'b1, 1'b0, lc_of(m_bcr) + 3, 1'b1);
        end_access();
        run_access(32'h010, 1'b0, 1'b0, lc_of(m_bcr) + 4, 1'b1);
        chk("burst_w0", 32'(rdata[0]), 32'h1111);
        chk("burst_w1", 32'(rdata[1]), 32'h2222);
        chk("burst_w2", 32'(rdata[2]), 32'h3333);
        chk("burst_w3", 32'(rdata[3]), 32'h4444);
        end_access();

        // Byte-mask table
        for (int i = 0; i < 4; i++) begin
            lc = lc_of(m_bcr);
            wdata[0] = tbl[i].prior; wub[0] = 1'b0; wlb[0] = 1'b0;
            run_access(tbl[i].a, 1'b1, 1'b0, lc, 1'b1);
            end_access();
            wdata[0] = tbl[i].newv; wub[0] = tbl[i].ub; wlb[0] = tbl[i].lb;
            run_access(tbl[i].a, 1'b1, 1'b0, lc, 1'b1);
            end_access();
            run_access(tbl[i].a, 1'b0, 1'b0, lc + 1, 1'b1);
            chk("mask_tbl", 32'(rdata[0]), 32'(tbl[i].expv));
            end_access();
        end

        // ce_n release mid-burst, then adv_n abort into the top of memory
        wdata[0] = 16'h7E57; wdata[1] = 16'h0BEE; wub[0] = 0; wlb[0] = 0; wub[1] = 0; wlb[1] = 0;
        run_access(32'h3FF, 1'b1, 1'b0, lc_of(m_bcr) + 1, 1'b1);
        end_access();
        run_access(32'h010, 1'b0, 1'b0, lc_of(m_bcr) + 3, 1'b1);
        end_access();
        run_access(32'h010, 1'b0, 1'b0, lc_of(m_bcr) + 1, 1'b1);
        run_access(32'h3FF, 1'b0, 1'b0, lc_of(m_bcr) + 2, 1'b1);
        chk("top_wrap0", 32'(rdata[0]), 32'h7E57);
        chk("top_wrap1", 32'(rdata[1]), 32'h0BEE);
        end_access();

        // Abort of a write burst: the abort edge must not write word 2
        fill_words(3);
        run_access(32'h052, 1'b1, 1'b0, lc_of(m_bcr), 1'b1);
        end_access();
        fill_words(3);
        run_access(32'h050, 1'b1, 1'b0, lc_of(m_bcr) + 1, 1'b1);
        run_access(32'h050, 1'b0, 1'b0, lc_of(m_bcr) + 3, 1'b1);
        end_access();

        // BCR = 0x1101: LC=2, WAIT active-low, early WAIT, wrap, length 4
        run_access((2 << 18) | 32'h1101, 1'b1, 1'b1, lc_of(m_bcr) + 2, 1'b1);
        end_access();
        run_access(32'h012, 1'b0, 1'b0, lc_of(m_bcr) + 6, 1'b1);
        chk("wrap_w0", 32'(rdata[0]), 32'h3333);
        chk("wrap_w1", 32'(rdata[1]), 32'h4444);
        chk("wrap_w2", 32'(rdata[2]), 32'h1111);
        chk("wrap_w3", 32'(rdata[3]), 32'h2222);
        end_access();

        // Reset during word 1 of a write
        wdata[0] = 16'h5555; wdata[1] = 16'h6666;
        wub[0] = 0; wlb[0] = 0; wub[1] = 0; wlb[1] = 0;
        run_access(32'h040, 1'b1, 1'b0, lc_of(m_bcr) + 1, 1'b1);
        end_access();
        wdata[0] = 16'hAAAA; wdata[1] = 16'hBBBB;
        run_access(32'h040, 1'b1, 1'b0, lc_of(m_bcr), 1'b1);
        dq_i = 16'hBBBB; ub_n = 1'b0; lb_n = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid_rst_dq_o", 32'(dq_o), 32'd0);
        chk("mid_rst_dq_oe", 32'(dq_oe), 32'd0);
        chk("mid_rst_wait", 32'(o_wait), 32'd0);
        chk("mid_rst_wait_oe", 32'(o_wait_oe), 32'd0);
        reset = 1'b0;
        m_bcr = 16'h1D1F;
        m_rcr = 16'h0010;
        ce_n = 1'b1;
        tick();
        run_access(2 << 18, 1'b0, 1'b1, lc_of(m_bcr) + 2, 1'b1);
        chk("bcr_after_rst", 32'(rdata[0]), 32'h1D1F);
        end_access();
        run_access(32'h040, 1'b0, 1'b0, lc_of(m_bcr) + 2, 1'b1);
        chk("rst_word0", 32'(rdata[0]), 32'hAAAA);
        chk("rst_word1", 32'(rdata[1]), 32'h6666);
        end_access();

        // Randomized accesses against the model
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 19));
            lc  = lc_of(m_bcr);
            if (sel < 3) begin
                case ($urandom_range(0, 5))
                    0: bl = 3'b001;
                    1: bl = 3'b010;
                    2: bl = 3'b011;
                    3: bl = 3'b111;
                    4: bl = 3'b000;
                    default: bl = 3'b100;
                endcase
                b = 16'h0000;
                b[14]    = 1'($urandom);
                b[13:11] = 3'($urandom);
                b[10]    = 1'($urandom);
                b[8]     = 1'($urandom);
                b[3]     = 1'($urandom);
                b[2:0]   = bl;
                run_access((2 << 18) | int'(b), 1'b1, 1'b1, int'($urandom_range(1, lc + 3)), 1'b1);
            end else if (sel == 3) begin
                run_access(int'($urandom_range(0, 65535)), 1'b1, 1'b1, lc + 1, 1'b1);
            end else if (sel == 4) begin
                a = ($urandom_range(0, 1) == 0) ? 0 : (2 << 18);
                run_access(a, 1'b0, 1'b1, int'($urandom_range(1, lc + 3)), 1'($urandom_range(0, 3) != 0));
            end else begin
                len = len_of(m_bcr);
                cyc = int'($urandom_range(1, lc + ((len == 0) ? 8 : len) + 2));
                a   = (($urandom_range(0, 1) == 0) ? 32'h100 : 32'h3F0) + int'($urandom_range(0, 15));
                for (int i = 0; i < 32; i++) begin
                    wdata[i] = 16'($urandom);
                    wub[i]   = ($urandom_range(0, 3) == 0);
                    wlb[i]   = ($urandom_range(0, 3) == 0);
                end
                run_access(a, 1'($urandom), 1'b0, cyc, 1'($urandom_range(0, 3) != 0));
            end
            if ($urandom_range(0, 2) != 0) end_access();
        end
        end_access();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
